// File: rtl/regfile_pkg.sv
// Shared types and default sizing for the multi-port register file.
package regfile_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_ADDR_W = 5;
  localparam int unsigned DEF_NR     = 4;
  localparam int unsigned DEF_NW     = 2;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/regfile_bypass.sv
// One read port's view of the write ports: highest-index matching write port wins.
module regfile_bypass #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned NW     = 2
) (
  input  logic [NW-1:0]        we,
  input  logic [NW*ADDR_W-1:0] waddr,
  input  logic [NW*DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0]    raddr,
  output logic [DATA_W-1:0]    data,
  output logic                 hit
);

  // Ascending scan so a later (higher-index) match overrides earlier ones.
  always_comb begin
    data = '0;
    hit  = 1'b0;
    for (int k = 0; k < int'(NW); k++) begin
      if (we[k] && (waddr[k*ADDR_W +: ADDR_W] == raddr) && (raddr != '0)) begin
        data = wdata[k*DATA_W +: DATA_W];
        hit  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port GPR file with post-reset clear sweep, write bypass and busy scoreboard.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned NR     = DEF_NR,
  parameter int unsigned NW     = DEF_NW
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 init_done,
  input  logic [NW-1:0]        we,
  input  logic [NW*ADDR_W-1:0] waddr,
  input  logic [NW*DATA_W-1:0] wdata,
  input  logic [NR-1:0]        re,
  input  logic [NR*ADDR_W-1:0] raddr,
  output logic [NR*DATA_W-1:0] rdata,
  input  logic                 alloc_en,
  input  logic [ADDR_W-1:0]    alloc_addr,
  output logic [NR-1:0]        rbusy
);

  localparam int unsigned NREG = 1 << ADDR_W;

  state_e              state, state_nxt;
  logic [ADDR_W-1:0]   cnt;
  logic [DATA_W-1:0]   regs [NREG];
  logic [NREG-1:0]     busy, busy_nxt;
  logic                sweep_last;
  logic                run;

  assign run        = (state == RUN);
  assign sweep_last = (cnt == ADDR_W'(NREG - 1));

  // State register, sweep counter and done flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= INIT;
      cnt       <= '0;
      init_done <= 1'b0;
      busy      <= '0;
    end else begin
      state <= state_nxt;
      busy  <= busy_nxt;
      if (state == INIT) begin
        cnt <= cnt + ADDR_W'(1);
        if (sweep_last) init_done <= 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      INIT:    if (sweep_last) state_nxt = RUN;
      RUN:     state_nxt = RUN;
      default: state_nxt = INIT;
    endcase
  end

  // Storage: sweep clears one entry per edge; in RUN later ports override earlier ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (state == INIT) begin
        regs[cnt] <= '0;
      end else begin
        for (int k = 0; k < int'(NW); k++) begin
          if (we[k] && (waddr[k*ADDR_W +: ADDR_W] != '0))
            regs[waddr[k*ADDR_W +: ADDR_W]] <= wdata[k*DATA_W +: DATA_W];
        end
      end
    end
  end

  // Scoreboard: writes retire a producer, alloc applied last so a new producer wins.
  always_comb begin
    busy_nxt = busy;
    if (run) begin
      for (int k = 0; k < int'(NW); k++) begin
        if (we[k]) busy_nxt[waddr[k*ADDR_W +: ADDR_W]] = 1'b0;
      end
      if (alloc_en) busy_nxt[alloc_addr] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  for (genvar i = 0; i < int'(NR); i++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] byp_data;
    logic              byp_hit;

    assign ra = raddr[i*ADDR_W +: ADDR_W];

    regfile_bypass #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .NW     (NW)
    ) u_byp (
      .we    (we),
      .waddr (waddr),
      .wdata (wdata),
      .raddr (ra),
      .data  (byp_data),
      .hit   (byp_hit)
    );

    always_comb begin
      rdata[i*DATA_W +: DATA_W] = '0;
      rbusy[i]                  = 1'b0;
      if (run && re[i] && (ra != '0)) begin
        rdata[i*DATA_W +: DATA_W] = byp_hit ? byp_data : regs[ra];
        rbusy[i]                  = busy[ra] & ~byp_hit;
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp.
module tb_regfile_mp;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned NR     = 4;
  localparam int unsigned NW     = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 init_done;
  logic [NW-1:0]        we;
  logic [NW*ADDR_W-1:0] waddr;
  logic [NW*DATA_W-1:0] wdata;
  logic [NR-1:0]        re;
  logic [NR*ADDR_W-1:0] raddr;
  logic [NR*DATA_W-1:0] rdata;
  logic                 alloc_en;
  logic [ADDR_W-1:0]    alloc_addr;
  logic [NR-1:0]        rbusy;

  int tests = 0;
  int fails = 0;

  regfile_mp #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .NR     (NR),
    .NW     (NW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .init_done  (init_done),
    .we         (we),
    .waddr      (waddr),
    .wdata      (wdata),
    .re         (re),
    .raddr      (raddr),
    .rdata      (rdata),
    .alloc_en   (alloc_en),
    .alloc_addr (alloc_addr),
    .rbusy      (rbusy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one edge and land 1ns after it, clear of the active edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = '0; waddr = '0; wdata = '0; alloc_en = 1'b0; alloc_addr = '0;
  endtask

  task automatic wr(input int p, input logic [4:0] a, input logic [31:0] d);
    we[p] = 1'b1;
    waddr[p*ADDR_W +: ADDR_W] = a;
    wdata[p*DATA_W +: DATA_W] = d;
  endtask

  task automatic rd_addr(input int p, input logic [4:0] a);
    raddr[p*ADDR_W +: ADDR_W] = a;
  endtask

  function automatic logic [31:0] rd(input int p);
    return rdata[p*DATA_W +: DATA_W];
  endfunction

  // Count edges until init_done rises, bounded.
  task automatic wait_init(output int n);
    n = 0;
    while (!init_done && n < 40) begin
      step();
      n++;
    end
  endtask

  int n;

  initial begin
    rst = 1'b0; re = '1; raddr = '0; idle();
    for (int p = 0; p < int'(NR); p++) rd_addr(p, 5'(p + 1));
    repeat (3) step();
    check("rst_init_done", 32'(init_done), 32'd0);
    check("rst_rdata0", rd(0), 32'd0);
    check("rst_rbusy", 32'(rbusy), 32'd0);

    // Release reset with a write pending that the sweep must ignore.
    rst = 1'b1;
    wr(0, 5'd5, 32'hDEADBEEF);
    rd_addr(0, 5'd5);
    #1;
    check("sweep_rdata", rd(0), 32'd0);
    wait_init(n);
    check("sweep_edges", 32'(n), 32'd32);
    idle();
    #1;
    check("r5_after_sweep", rd(0), 32'd0);

    // Two ports write r7; port 1 must win on every read port.
    wr(0, 5'd7, 32'h11);
    wr(1, 5'd7, 32'h22);
    for (int p = 0; p < int'(NR); p++) rd_addr(p, 5'd7);
    #1;
    for (int p = 0; p < int'(NR); p++) check($sformatf("byp_prio_p%0d", p), rd(p), 32'h22);
    step();
    idle();
    #1;
    for (int p = 0; p < int'(NR); p++) check($sformatf("arr_prio_p%0d", p), rd(p), 32'h22);

    // r0 stays zero; disabled read port returns zero.
    wr(0, 5'd0, 32'hFFFFFFFF);
    rd_addr(0, 5'd0);
    #1;
    check("r0_bypass", rd(0), 32'd0);
    step();
    idle();
    wr(1, 5'd3, 32'h55);
    step();
    idle();
    re = 4'b1011;
    rd_addr(1, 5'd3);
    rd_addr(2, 5'd3);
    #1;
    check("r0_array", rd(0), 32'd0);
    check("re_on_r3", rd(1), 32'h55);
    check("re_off_r3", rd(2), 32'd0);
    re = '1;

    // Scoreboard: alloc r9, then retire with a bypassed write.
    alloc_en = 1'b1; alloc_addr = 5'd9;
    rd_addr(0, 5'd9);
    #1;
    check("alloc_same_cycle", 32'(rbusy[0]), 32'd0);
    step();
    idle();
    #1;
    check("alloc_busy", 32'(rbusy[0]), 32'd1);
    wr(0, 5'd9, 32'hABCD);
    #1;
    check("wr_busy_masked", 32'(rbusy[0]), 32'd0);
    check("wr_bypass_data", rd(0), 32'hABCD);
    step();
    idle();
    #1;
    check("busy_cleared", 32'(rbusy[0]), 32'd0);
    check("r9_array", rd(0), 32'hABCD);

    // Alloc and write to the same register: busy must remain set.
    alloc_en = 1'b1; alloc_addr = 5'd4;
    wr(1, 5'd4, 32'h1);
    rd_addr(0, 5'd4);
    step();
    idle();
    #1;
    check("collide_busy", 32'(rbusy[0]), 32'd1);
    check("collide_data", rd(0), 32'h1);

    // Mid-run reset wipes busy and restarts the sweep.
    wr(0, 5'd3, 32'h77);
    step();
    idle();
    alloc_en = 1'b1; alloc_addr = 5'd3;
    rd_addr(0, 5'd3);
    step();
    idle();
    #1;
    check("pre_rst_busy", 32'(rbusy[0]), 32'd1);
    check("pre_rst_data", rd(0), 32'h77);
    rst = 1'b0;
    step();
    rst = 1'b1;
    #1;
    check("midrst_rbusy", 32'(rbusy[0]), 32'd0);
    check("midrst_init_done", 32'(init_done), 32'd0);
    wait_init(n);
    check("midrst_sweep_edges", 32'(n), 32'd32);
    #1;
    check("r3_after_resweep", rd(0), 32'd0);
    check("r3_busy_after", 32'(rbusy[0]), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port general-purpose register file for the superscalar integer pipeline. It supersedes the single-issue two-read/one-write file. It adds configurable read and write port counts, deterministic write-port priority and same-cycle bypass on every read port. A hardware clear sweep after reset and a per-register busy scoreboard are used by issue logic for RAW hazard detection.

## Interface
- DATA_W, 32, register width
- ADDR_W, 5, address width; NREG = 2**ADDR_W registers, r0 hardwired zero
- NR, 4, number of read ports
- NW, 2, number of write ports
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, synchronous, active-low (rst==0 resets)
- init_done  out  1  high once clear sweep complete
- we  in  NW  per-port write enable
- waddr  in  NW*ADDR_W  write addresses, port k at [k*ADDR_W +: ADDR_W]
- wdata  in  NW*DATA_W  write data
- re  in  NR  per-port read enable
- raddr  in  NR*ADDR_W  read addresses
- rdata  out  NR*DATA_W  read data, combinational
- alloc_en  in  1  mark alloc_addr busy (destination allocated at issue)
- alloc_addr  in  ADDR_W  register to mark busy
- rbusy  out  NR  busy flag of raddr[i], combinational

## Operation
- FSM states INIT, RUN. Any clock edge with rst==0: state<=INIT, clear counter<=0, all busy bits<=0, init_done<=0.
- INIT, rst==1: regs[cnt]<=0, cnt<=cnt+1. On the edge clearing cnt==NREG-1: state<=RUN, init_done<=1. Clear takes NREG edges after rst rises.
- In INIT: we and alloc_en ignored; rdata all zero; rbusy all zero.
- RUN write: port k writes regs[waddr_k]<=wdata_k when we[k] and waddr_k!=0. Same address on several ports: highest-index enabled port wins, others dropped.
- RUN read port i:
  - re[i]==0 or raddr_i==0: rdata_i=0.
  - Else if any enabled write port has waddr==raddr_i (nonzero): rdata_i = wdata of the highest such port (bypass).
  - Else rdata_i=regs[raddr_i].
- Scoreboard (RUN only):
  - Enabled write to nonzero address clears busy[waddr] next edge.
  - alloc_en with nonzero alloc_addr sets busy[alloc_addr] next edge.
  - alloc and write to same address in the same cycle: busy ends set (newer producer wins).
  - busy[0] constant 0.
- rbusy[i] = re[i] & busy[raddr_i] & ~bypass_hit_i. A value being written this cycle is not reported busy.

## Timing
- Reset values: init_done 0, rdata 0, rbusy 0, busy[] 0, state INIT, regs 0 after sweep.
- Write-to-read latency: 0 cycles via bypass; from array on the next cycle.
- Alloc-to-rbusy latency: 1 cycle.
- Reset asserted mid-sweep or mid-run restarts the sweep from r0. In-flight writes on that edge are lost.
- rst deasserted with we high on the first INIT cycle: the write is ignored.

## Structure
- Package regfile_pkg holds the state enum typedef (INIT/RUN) and default parameter constants. The existing RegBus/RegAddrBus/ZeroWord macros in define.vh remain the width source for the CPU top-level instance (DATA_W=32, ADDR_W=5).
- Sub-module regfile_bypass: one read port's priority select over NW write ports, returning data and a hit flag. Instantiated NR times by generate.
- Storage, FSM, counter and scoreboard live in regfile_mp.

## Test plan
- Reset sweep: hold rst=0 3 cycles, release → init_done high exactly 32 edges later. During the sweep, we=1 to r5=0xDEADBEEF has no effect; afterwards r5 reads 0.
- Bypass priority: we=2'b11, waddr0=waddr1=7, wdata0=0x11, wdata1=0x22, read r7 on all ports → 0x22 same cycle and next cycle.
- r0 and re: write r0=0xFFFFFFFF → reads 0. re[2]=0 with raddr2=3 holding 0x55 → rdata2=0.
- Scoreboard: alloc r9 → rbusy on r9 next cycle. Write r9=0xABCD → rbusy 0 and rdata 0xABCD in the same cycle. Busy cleared next edge.
- Alloc/write collision: alloc r4 and write r4=0x1 in the same cycle → next cycle rbusy(r4)=1, rdata=0x1.
- Mid-run reset: set busy r3 and write r3=0x77, pulse rst=0 one cycle → rbusy 0, init_done 0 for 32 cycles, r3 then reads 0.
